axis_ddr_rd_checker: RTL

// - Downstream consumer of the DDR buffer's AXIS master (read-back) stream in the DDR bandwidth test.
// - Checks every received beat against the lane-counter pattern produced by the upstream generator.
// - Checks tlast placement at burst boundaries and on the final beat.
// - Counts data errors, tlast errors and elapsed cycles so software can compute read bandwidth and integrity.

---
 rtl/axis_ddr_test_pkg.sv | 23 ++
 rtl/axis_pattern_cmp.sv | 50 +++++
 rtl/axis_ddr_rd_checker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/axis_ddr_test_pkg.sv
// Shared definitions for the DDR bandwidth test: checker FSM states and the
// lane-counter data pattern that both the generator and the checker use.
package axis_ddr_test_pkg;

    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        RUN,
        DONE
    } state_t;

    // Word carried by lane `lane` of beat `idx` on a bus of `lanes` 32-bit lanes.
    function automatic logic [LANE_W-1:0] pattern_word(
        input logic [LANE_W-1:0] idx,
        input int unsigned       lanes,
        input int unsigned       lane
    );
        return LANE_W'(idx * lanes + lane);
    endfunction

endpackage

// File: rtl/axis_pattern_cmp.sv
// Registered beat checker: compares one accepted AXIS beat against the lane
// pattern and the expected tlast, flagging errors on the cycle after the handshake.
module axis_pattern_cmp
    import axis_ddr_test_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_SIZE = 15,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  hs,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tlast,
    input  logic [CNT_WIDTH-1:0]  idx,
    input  logic [CNT_WIDTH-1:0]  last_idx,
    output logic                  data_err,
    output logic                  last_err
);

    localparam int unsigned          LANES      = DATA_WIDTH / LANE_W;
    localparam logic [CNT_WIDTH-1:0] BURST_LEN  = CNT_WIDTH'(BURST_SIZE + 1);
    localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(BURST_SIZE);

    logic data_mis;
    logic exp_last;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        data_mis = 1'b0;
        for (int k = 0; k < int'(LANES); k++) begin
            if (tdata[k*LANE_W +: LANE_W] != pattern_word(LANE_W'(idx), LANES, unsigned'(k)))
                data_mis = 1'b1;
        end
    end

    assign exp_last = ((idx % BURST_LEN) == BURST_LAST) || (idx == last_idx);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            data_err <= 1'b0;
            last_err <= 1'b0;
        end else begin
            data_err <= hs & data_mis;
            last_err <= hs & (tlast != exp_last);
        end
    end

endmodule

// File: rtl/axis_ddr_rd_checker.sv
// Read-back checker for the DDR bandwidth test: consumes the AXIS stream,
// checks data pattern and tlast placement, and reports counts and timing.
module axis_ddr_rd_checker
    import axis_ddr_test_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_SIZE = 15,
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = 4096
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic [CNT_WIDTH-1:0]    nbeats,
    input  logic                    pause,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    cycle_cnt,
    output logic [CNT_WIDTH-1:0]    err_cnt,
    output logic [CNT_WIDTH-1:0]    tlast_err_cnt,
    output logic                    first_err_valid,
    output logic [CNT_WIDTH-1:0]    first_err_idx
);

    localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ALL_ONES    = '1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT - 1);

    state_t               state, state_nx;
    logic                 hs, start_ok, final_beat, idle_expired;
    logic                 data_err, last_err;
    logic [CNT_WIDTH-1:0] last_idx, idle_cnt;
    logic [CNT_WIDTH-1:0] err_q, tlast_err_q, first_idx_q;
    logic                 first_valid_q;
    logic                 unused_tstrb;

    assign unused_tstrb  = ^s_axis_tstrb;

    assign busy          = (state == WAIT_FIRST) || (state == RUN);
    assign done          = (state == DONE);
    assign s_axis_tready = busy & ~pause;
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign start_ok      = start & ((state == IDLE) || (state == DONE));
    assign final_beat    = hs && (beat_cnt == last_idx);
    assign idle_expired  = busy && !hs && (idle_cnt == TIMEOUT_LIM);

    axis_pattern_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_SIZE (BURST_SIZE),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_cmp (
        .aclk     (aclk),
        .areset   (areset),
        .hs       (hs),
        .tdata    (s_axis_tdata),
        .tlast    (s_axis_tlast),
        .idx      (beat_cnt),
        .last_idx (last_idx),
        .data_err (data_err),
        .last_err (last_err)
    );

    // Compare results land one cycle after the handshake; folding them in here
    // keeps the reported error figures aligned with beat_cnt.
    assign err_cnt         = (err_q == ALL_ONES) ? err_q : err_q + CNT_WIDTH'(data_err);
    assign tlast_err_cnt   = (tlast_err_q == ALL_ONES) ? tlast_err_q
                                                       : tlast_err_q + CNT_WIDTH'(last_err);
    assign first_err_valid = first_valid_q | data_err;
    assign first_err_idx   = first_valid_q ? first_idx_q
                           : (data_err ? beat_cnt - ONE : '0);

    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nx = (nbeats == '0) ? DONE : WAIT_FIRST;
            end
            WAIT_FIRST, RUN: begin
                if (final_beat || idle_expired)   state_nx = DONE;
                else if (state == WAIT_FIRST && hs) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_cnt      <= '0;
            cycle_cnt     <= '0;
            idle_cnt      <= '0;
            last_idx      <= '0;
            err_q         <= '0;
            tlast_err_q   <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            timeout       <= 1'b0;
        end else if (start_ok) begin
            beat_cnt      <= '0;
            cycle_cnt     <= '0;
            idle_cnt      <= '0;
            last_idx      <= nbeats - ONE;
            err_q         <= '0;
            tlast_err_q   <= '0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            timeout       <= 1'b0;
        end else begin
            err_q         <= err_cnt;
            tlast_err_q   <= tlast_err_cnt;
            first_valid_q <= first_err_valid;
            first_idx_q   <= first_err_idx;
            if (busy) begin
                if (hs) begin
                    beat_cnt <= beat_cnt + ONE;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + ONE;
                end
                if (state == RUN)  cycle_cnt <= cycle_cnt + ONE;
                else if (hs)       cycle_cnt <= ONE;
                if (idle_expired)  timeout <= 1'b1;
            end
        end
    end

endmodule
